// File: rtl/rvi_bj_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// rvi_bj_redirect_ctrl
//
// Purpose:
//   Sits behind the Rvi branch/jump execute stage. For every resolved
//   branch/jump it compares the architecturally correct next-PC with the
//   fetch-stage prediction. On a mispredict it pulses a flush for the
//   younger stages and raises a held redirect request towards fetch
//   (valid/ready). Taken targets with bit 0 set are reported as misaligned
//   instead of being redirected. A saturating counter tracks mispredicts.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   ex_vld / ex_rdy   EX result handshake (accept = ex_vld & ex_rdy)
//   ex_bj             instruction is a branch/jump
//   ex_taken, ex_tgt  resolved direction and target
//   ex_pc             instruction pc
//   ex_link_offset    01 = 16-bit instr, 10 = 32-bit instr (halfwords)
//   ex_pred_taken     fetch predicted taken
//   ex_pred_tgt       fetch predicted target
//   redir_vld/rdy     redirect request handshake towards fetch
//   redir_pc          redirect address, stable while redir_vld is high
//   flush             one-cycle flush pulse for younger stages
//   misalign          one-cycle pulse: taken target misaligned
//   mispred_cnt       saturating mispredict counter
// ---------------------------------------------------------------------------
module rvi_bj_redirect_ctrl #(
  parameter int RV64      = 0,
  parameter int CPU_WIDTH = 32 * (RV64 + 1),
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_vld,
  output logic                 ex_rdy,
  input  logic                 ex_bj,
  input  logic                 ex_taken,
  input  logic [CPU_WIDTH-1:0] ex_tgt,
  input  logic [CPU_WIDTH-1:0] ex_pc,
  input  logic [1:0]           ex_link_offset,
  input  logic                 ex_pred_taken,
  input  logic [CPU_WIDTH-1:0] ex_pred_tgt,
  output logic                 redir_vld,
  input  logic                 redir_rdy,
  output logic [CPU_WIDTH-1:0] redir_pc,
  output logic                 flush,
  output logic                 misalign,
  output logic [CNT_W-1:0]     mispred_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic                   redir_vld_q, redir_vld_d;
  logic [CPU_WIDTH-1:0]   redir_pc_q, redir_pc_d;
  logic                   flush_q, flush_d;
  logic                   misalign_q, misalign_d;
  logic [CNT_W-1:0]       mispred_cnt_q, mispred_cnt_d;

  logic                   accept;
  logic [CPU_WIDTH-1:0]   fall_pc;
  logic [CPU_WIDTH-1:0]   act_pc;
  logic [CPU_WIDTH-1:0]   pred_pc;

  // ex_rdy must drop the instant rst rises, so it is gated with rst
  // combinationally rather than relying on the state register alone.
  assign ex_rdy = (state_q == IDLE) && !rst;
  assign accept = ex_vld && ex_rdy;

  // Link offset is in halfwords; shifting left by one gives the byte
  // increment (2 or 4). Sums wrap at CPU_WIDTH bits.
  assign fall_pc = ex_pc + {{(CPU_WIDTH-3){1'b0}}, ex_link_offset, 1'b0};
  assign act_pc  = ex_taken      ? ex_tgt      : fall_pc;
  assign pred_pc = ex_pred_taken ? ex_pred_tgt : fall_pc;

  always_comb begin
    state_d       = state_q;
    redir_vld_d   = redir_vld_q;
    redir_pc_d    = redir_pc_q;
    flush_d       = 1'b0;
    misalign_d    = 1'b0;
    mispred_cnt_d = mispred_cnt_q;

    unique case (state_q)
      IDLE: begin
        // Misalignment wins over mispredict: a bad target is never used
        // as a redirect address.
        if (accept && ex_bj) begin
          if (ex_taken && ex_tgt[0]) begin
            misalign_d = 1'b1;
          end else if (act_pc != pred_pc) begin
            flush_d     = 1'b1;
            redir_vld_d = 1'b1;
            redir_pc_d  = act_pc;
            if (mispred_cnt_q != {CNT_W{1'b1}}) begin
              mispred_cnt_d = mispred_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            state_d = PEND;
          end
        end
      end
      PEND: begin
        // redir_pc is left untouched so it stays stable until accepted.
        if (redir_rdy) begin
          redir_vld_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      redir_vld_q   <= 1'b0;
      redir_pc_q    <= '0;
      flush_q       <= 1'b0;
      misalign_q    <= 1'b0;
      mispred_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      redir_vld_q   <= redir_vld_d;
      redir_pc_q    <= redir_pc_d;
      flush_q       <= flush_d;
      misalign_q    <= misalign_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign redir_vld   = redir_vld_q;
  assign redir_pc    = redir_pc_q;
  assign flush       = flush_q;
  assign misalign    = misalign_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_rvi_bj_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rvi_bj_redirect_ctrl
//
// Directed bench for rvi_bj_redirect_ctrl (32-bit, 2-bit counter so that
// saturation is reachable). Each stimulus call carries its hand-computed
// expected response, which is queued; an independent monitor pops an entry
// whenever the DUT shows a flush or misalign pulse and compares it.
// ---------------------------------------------------------------------------
module tb_rvi_bj_redirect_ctrl;

  localparam int CW = 32;
  localparam int NW = 2;

  logic          clk;
  logic          rst;
  logic          ex_vld;
  logic          ex_rdy;
  logic          ex_bj;
  logic          ex_taken;
  logic [CW-1:0] ex_tgt;
  logic [CW-1:0] ex_pc;
  logic [1:0]    ex_link_offset;
  logic          ex_pred_taken;
  logic [CW-1:0] ex_pred_tgt;
  logic          redir_vld;
  logic          redir_rdy;
  logic [CW-1:0] redir_pc;
  logic          flush;
  logic          misalign;
  logic [NW-1:0] mispred_cnt;

  typedef struct packed {
    logic          is_flush;
    logic [CW-1:0] pc;
    logic [NW-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  rvi_bj_redirect_ctrl #(
    .RV64      (0),
    .CPU_WIDTH (CW),
    .CNT_W     (NW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_vld         (ex_vld),
    .ex_rdy         (ex_rdy),
    .ex_bj          (ex_bj),
    .ex_taken       (ex_taken),
    .ex_tgt         (ex_tgt),
    .ex_pc          (ex_pc),
    .ex_link_offset (ex_link_offset),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_tgt    (ex_pred_tgt),
    .redir_vld      (redir_vld),
    .redir_rdy      (redir_rdy),
    .redir_pc       (redir_pc),
    .flush          (flush),
    .misalign       (misalign),
    .mispred_cnt    (mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every flush or misalign pulse must match the next queued entry.
  always @(negedge clk) begin
    if (!rst && (flush === 1'b1 || misalign === 1'b1)) begin
      if (sb_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_pulse: got flush=%0b misalign=%0b pc=0x%0h, expected no pulse",
                 flush, misalign, redir_pc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("mon_flush",     64'(flush),       64'(e.is_flush));
        check("mon_misalign",  64'(misalign),    64'(!e.is_flush));
        check("mon_redir_vld", 64'(redir_vld),   64'(e.is_flush));
        if (e.is_flush) check("mon_redir_pc", 64'(redir_pc), 64'(e.pc));
        check("mon_cnt",       64'(mispred_cnt), 64'(e.cnt));
      end
    end
  end

  // Present one EX result, wait (bounded) for acceptance, and queue the
  // expected response when one is due.
  task automatic apply_ex(input logic bj, input logic taken,
                          input logic [CW-1:0] tgt, input logic [CW-1:0] pc,
                          input logic [1:0] lo, input logic pt,
                          input logic [CW-1:0] ptgt, input logic has_resp,
                          input logic is_flush, input logic [CW-1:0] exp_pc,
                          input logic [NW-1:0] exp_cnt);
    int waited;
    @(negedge clk);
    ex_bj = bj; ex_taken = taken; ex_tgt = tgt; ex_pc = pc;
    ex_link_offset = lo; ex_pred_taken = pt; ex_pred_tgt = ptgt;
    ex_vld = 1'b1;
    waited = 0;
    while (ex_rdy !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (ex_rdy !== 1'b1) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL accept_timeout: got ex_rdy=%0b, expected 1", ex_rdy);
    end else begin
      if (has_resp) sb_q.push_back('{is_flush, exp_pc, exp_cnt});
      @(posedge clk);
    end
    #1 ex_vld = 1'b0;
  endtask

  // Hold off the redirect for 'waits' cycles checking it stays stable,
  // then accept it and check the return to IDLE.
  task automatic release_redir(input int waits, input logic [CW-1:0] exp_pc);
    redir_rdy = 1'b0;
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      check("hold_redir_vld", 64'(redir_vld), 64'd1);
      check("hold_redir_pc",  64'(redir_pc),  64'(exp_pc));
      check("hold_ex_rdy",    64'(ex_rdy),    64'd0);
    end
    ex_vld = 1'b0;
    redir_rdy = 1'b1;
    @(posedge clk);
    #1 redir_rdy = 1'b0;
    @(negedge clk);
    check("post_redir_vld", 64'(redir_vld), 64'd0);
    check("post_ex_rdy",    64'(ex_rdy),    64'd1);
  endtask

  task automatic wait_drain(input string name);
    repeat (3) @(negedge clk);
    check(name, 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1; ex_vld = 1'b0; ex_bj = 1'b0; ex_taken = 1'b0;
    ex_tgt = '0; ex_pc = '0; ex_link_offset = 2'b10; ex_pred_taken = 1'b0;
    ex_pred_tgt = '0; redir_rdy = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ex_rdy",    64'(ex_rdy),      64'd0);
    check("rst_redir_vld", 64'(redir_vld),   64'd0);
    check("rst_cnt",       64'(mispred_cnt), 64'd0);
    rst = 1'b0;
    #1 check("rel_ex_rdy", 64'(ex_rdy), 64'd1);

    // Correct prediction; redir_rdy high in IDLE must be ignored
    redir_rdy = 1'b1;
    apply_ex(1, 1, 32'h180, 32'h100, 2'b10, 1, 32'h180, 0, 0, 0, 0);
    @(negedge clk);
    check("ok_flush",     64'(flush),     64'd0);
    check("ok_redir_vld", 64'(redir_vld), 64'd0);
    check("ok_ex_rdy",    64'(ex_rdy),    64'd1);
    redir_rdy = 1'b0;

    // Non-branch with a bogus prediction: no effect
    apply_ex(0, 0, 32'h0, 32'h100, 2'b10, 1, 32'h900, 0, 0, 0, 0);
    wait_drain("nobj_drain");

    // Not-taken mispredict: 0x100 + 4
    apply_ex(1, 0, 32'h300, 32'h100, 2'b10, 1, 32'h200, 1, 1, 32'h104, 2'd1);
    // Backpressure, with a competing EX result that must not be taken
    ex_bj = 1'b1; ex_taken = 1'b1; ex_tgt = 32'h500; ex_pred_taken = 1'b0;
    ex_vld = 1'b1;
    release_redir(3, 32'h104);
    wait_drain("bp_drain");

    // Misaligned taken target
    apply_ex(1, 1, 32'h181, 32'h100, 2'b10, 0, 32'h0, 1, 0, 0, 2'd1);
    wait_drain("mis_drain");

    // Wrap: 0xFFFF_FFFE + 2 = 0
    apply_ex(1, 0, 32'h0, 32'hFFFF_FFFE, 2'b01, 1, 32'h40, 1, 1, 32'h0, 2'd2);
    release_redir(0, 32'h0);

    // Taken but predicted not-taken
    apply_ex(1, 1, 32'h200, 32'h100, 2'b10, 0, 32'h0, 1, 1, 32'h200, 2'd3);
    release_redir(1, 32'h200);

    // Targets differing only in bit 31; counter already saturated
    apply_ex(1, 1, 32'h180, 32'h100, 2'b10, 1, 32'h8000_0180, 1, 1, 32'h180, 2'd3);
    // Reset while pending
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_redir_vld", 64'(redir_vld),   64'd0);
    check("arst_redir_pc",  64'(redir_pc),    64'd0);
    check("arst_flush",     64'(flush),       64'd0);
    check("arst_cnt",       64'(mispred_cnt), 64'd0);
    check("arst_ex_rdy",    64'(ex_rdy),      64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arel_ex_rdy", 64'(ex_rdy),      64'd1);
    check("arel_cnt",    64'(mispred_cnt), 64'd0);
    wait_drain("rst_drain");

    // Saturation: 1,2,3,3,3
    apply_ex(1, 0, 32'h0, 32'h1000, 2'b10, 1, 32'h2000, 1, 1, 32'h1004, 2'd1);
    release_redir(0, 32'h1004);
    apply_ex(1, 0, 32'h0, 32'h1010, 2'b01, 1, 32'h2000, 1, 1, 32'h1012, 2'd2);
    release_redir(0, 32'h1012);
    apply_ex(1, 1, 32'h3000, 32'h1020, 2'b10, 0, 32'h0, 1, 1, 32'h3000, 2'd3);
    release_redir(0, 32'h3000);
    apply_ex(1, 1, 32'h3100, 32'h1030, 2'b10, 1, 32'h3104, 1, 1, 32'h3100, 2'd3);
    release_redir(0, 32'h3100);
    apply_ex(1, 0, 32'h0, 32'h1040, 2'b10, 1, 32'h1040, 1, 1, 32'h1044, 2'd3);
    release_redir(0, 32'h1044);
    wait_drain("sat_drain");
    check("final_cnt", 64'(mispred_cnt), 64'd3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
